coin_return_ctrl: RTL and testbench
===================================

Name: coin_return_ctrl

Overview:
Parametrised successor to the vending machine's timeout/coin-return logic. Tracks an inactivity timer and starts a return sequence on timeout or on a user return request. The return is sequential and greedy, one coin per cycle, for any number of coin denominations. Sits between the coin-input/total-keeping logic and the coin dispenser; the totaling unit subtracts each reported return amount.

Parameters:
NUM_COINS, 3, number of coin denominations; index 0 is the smallest value, values are strictly ascending with index.
VALUE_BITS, 32, width of each coin value.
TOTAL_BITS, 31, width of the running-total bus (matches kTotalBits).
WAIT_CYCLES, 10, inactivity timeout in clock cycles (matches kWaitTime); must be >= 1.
TIMER_BITS, 32, width of the wait timer.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
i_input_coin  in  NUM_COINS  one-hot or zero; coin inserted this cycle
o_output_item_any  in  1  an item was dispensed this cycle
i_trigger_return  in  1  user return request, level or pulse
i_current_total  in  TOTAL_BITS  current balance from the totaling unit
i_coin_value  in  NUM_COINS*VALUE_BITS  packed coin values; coin k is at [k*VALUE_BITS +: VALUE_BITS]
o_return_coin  out  NUM_COINS  one-hot coin dispensed this cycle, or zero
o_return_amount  out  TOTAL_BITS  value of o_return_coin, for upstream subtraction
o_reject_coin  out  NUM_COINS  echo of i_input_coin received while busy
o_busy  out  1  return sequence in progress
o_residual  out  TOTAL_BITS  amount left unreturnable (below smallest coin), valid in DONE
o_wait_time  out  TIMER_BITS  current timer value

Behaviour:
- Reset (async, reset_n=0):
  - FSM=IDLE, timer=WAIT_CYCLES, remaining=0.
  - All outputs are 0 except o_wait_time=WAIT_CYCLES.
  - Reset mid-return aborts immediately; no further coins are emitted.
- FSM states: IDLE, RETURN, DONE.
- IDLE timer, per cycle, in priority order:
  - i_trigger_return -> timer<=0.
  - Else if i_input_coin!=0 or o_output_item_any -> timer<=WAIT_CYCLES.
  - Else if timer>0 -> timer<=timer-1.
  - At 0, the timer holds.
- IDLE -> RETURN: when (timer==0 or i_trigger_return) and i_current_total>0, on the same edge:
  - Latch remaining<=i_current_total.
  - o_busy<=1.
  - Coins arriving on this edge are still counted by upstream.
- IDLE, timer==0, total==0: stay in IDLE. The next coin reloads the timer.
- RETURN, each cycle (registered outputs):
  - Pick k = highest index with coin_value[k] <= remaining.
  - If such k exists: o_return_coin<=1<<k, o_return_amount<=coin_value[k], remaining<=remaining-coin_value[k].
  - If none exists: o_return_coin<=0, o_residual<=remaining, go to DONE.
  - First coin appears 1 cycle after entering RETURN.
  - The sequence takes exactly N coin cycles plus 1 cycle.
- RETURN -> DONE also occurs when remaining reaches 0 after a subtraction: residual=0.
- DONE (one cycle): o_return_coin=0, o_busy stays 1, then -> IDLE with timer<=WAIT_CYCLES and o_busy<=0.
- While busy (RETURN or DONE):
  - i_input_coin is echoed on o_reject_coin the next cycle.
  - It is not counted toward remaining.
  - i_trigger_return and o_output_item_any are ignored.
  - The timer is frozen.
- Zero-valued coin entries are never selected.
- All comparisons and subtractions are unsigned at TOTAL_BITS. Coin values are zero-extended or truncated to TOTAL_BITS.
- No combinational path from any input to any output.

Decomposition:
- Shared package / vending_machine_def.v:
  - kNumCoins, kTotalBits, kWaitTime defaults.
  - FSM state encodings: IDLE=2'd0, RETURN=2'd1, DONE=2'd2.
- One sub-module, greedy_coin_select: combinational; inputs remaining and packed values; outputs a one-hot select, the selected value, and a found flag. It is reusable by the change-dispense path.

Test Plan:
1. Timeout return: values {100,500,1000}; insert 1000, 500, 100 (total 1600); idle 10 cycles -> o_return_coin 3'b100, 3'b010, 3'b001 on consecutive cycles, amounts 1000/500/100, residual 0, o_busy low 2 cycles after the last coin.
2. Trigger with repeats: total 2700 and i_trigger_return pulse -> coins 100,100,010,001,001; residual 0; five coin cycles.
3. Residual: values {100,500,1000}, total 650 -> coins 010 then 001; residual 50 in DONE.
4. Timer reload: coin at timer=3 -> timer=10 next cycle; item output at timer=1 -> timer=10 next cycle; no return when total=0 at timeout.
5. Busy reject: insert coin 3'b001 during RETURN -> o_reject_coin=3'b001 next cycle; return sequence unchanged.
6. Async reset mid-RETURN after first coin -> all outputs 0 immediately; timer=10 and IDLE after release.

Source files
------------

// File: rtl/coin_return_ctrl_pkg.sv
// Shared defaults and FSM encoding for the coin-return controller.
// Imported by the interface, the top and the testbench.
package coin_return_ctrl_pkg;

   localparam int K_NUM_COINS  = 3;
   localparam int K_VALUE_BITS = 32;
   localparam int K_TOTAL_BITS = 31;
   localparam int K_WAIT_TIME  = 10;
   localparam int K_TIMER_BITS = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RETURN = 2'd1,
      DONE   = 2'd2
   } state_e;

endpackage

// File: rtl/coin_return_ctrl_if.sv
// Signal bundle between the coin/total logic, the return controller and the dispenser.
// The controller uses the slave modport; the upstream side uses master.
interface coin_return_ctrl_if
   import coin_return_ctrl_pkg::*;
#(
   parameter int NUM_COINS  = K_NUM_COINS,
   parameter int VALUE_BITS = K_VALUE_BITS,
   parameter int TOTAL_BITS = K_TOTAL_BITS,
   parameter int TIMER_BITS = K_TIMER_BITS
);

   logic [NUM_COINS-1:0]            i_input_coin;
   logic                            o_output_item_any;
   logic                            i_trigger_return;
   logic [TOTAL_BITS-1:0]           i_current_total;
   logic [NUM_COINS*VALUE_BITS-1:0] i_coin_value;
   logic [NUM_COINS-1:0]            o_return_coin;
   logic [TOTAL_BITS-1:0]           o_return_amount;
   logic [NUM_COINS-1:0]            o_reject_coin;
   logic                            o_busy;
   logic [TOTAL_BITS-1:0]           o_residual;
   logic [TIMER_BITS-1:0]           o_wait_time;

   modport master (
      output i_input_coin, o_output_item_any, i_trigger_return, i_current_total, i_coin_value,
      input  o_return_coin, o_return_amount, o_reject_coin, o_busy, o_residual, o_wait_time
   );

   modport slave (
      input  i_input_coin, o_output_item_any, i_trigger_return, i_current_total, i_coin_value,
      output o_return_coin, o_return_amount, o_reject_coin, o_busy, o_residual, o_wait_time
   );

endinterface

// File: rtl/greedy_coin_select.sv
// Combinational greedy pick: highest-index coin whose value fits in the remaining amount.
// Shared with the change-dispense path, so it carries no state.
module greedy_coin_select #(
   parameter int NUM_COINS  = 3,
   parameter int VALUE_BITS = 32,
   parameter int TOTAL_BITS = 31
) (
   input  logic [TOTAL_BITS-1:0]           remaining_i,
   input  logic [NUM_COINS*VALUE_BITS-1:0] coin_value_i,
   output logic [NUM_COINS-1:0]            sel_o,
   output logic [TOTAL_BITS-1:0]           value_o,
   output logic                            found_o
);

   logic [TOTAL_BITS-1:0] val_k;

   // Ascending scan so the last fitting entry (highest index) wins; zero entries never fit.
   always_comb begin
      sel_o   = '0;
      value_o = '0;
      found_o = 1'b0;
      val_k   = '0;
      for (int k = 0; k < NUM_COINS; k++) begin
         val_k = TOTAL_BITS'(coin_value_i[k*VALUE_BITS +: VALUE_BITS]);
         if (val_k != '0 && val_k <= remaining_i) begin
            sel_o    = '0;
            sel_o[k] = 1'b1;
            value_o  = val_k;
            found_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/coin_return_ctrl.sv
// Inactivity timer plus sequential greedy coin return, one coin per cycle.
// All outputs are registered; the totaling unit subtracts o_return_amount.
//
// state  | meaning
// IDLE   | counting down inactivity, watching for timeout or return request
// RETURN | emitting one coin per cycle from the latched remaining amount
// DONE   | one cycle, no coin, residual valid, busy still high
module coin_return_ctrl
   import coin_return_ctrl_pkg::*;
#(
   parameter int NUM_COINS   = K_NUM_COINS,
   parameter int VALUE_BITS  = K_VALUE_BITS,
   parameter int TOTAL_BITS  = K_TOTAL_BITS,
   parameter int WAIT_CYCLES = K_WAIT_TIME,
   parameter int TIMER_BITS  = K_TIMER_BITS
) (
   input logic               clk,
   input logic               reset_n,
   coin_return_ctrl_if.slave bus
);

   localparam logic [TIMER_BITS-1:0] WAIT_LOAD = TIMER_BITS'(WAIT_CYCLES);

   state_e                state_q;
   logic [TIMER_BITS-1:0] timer_q;
   logic [TOTAL_BITS-1:0] remaining_q;
   logic [NUM_COINS-1:0]  return_coin_q;
   logic [TOTAL_BITS-1:0] return_amount_q;
   logic [NUM_COINS-1:0]  reject_q;
   logic                  busy_q;
   logic [TOTAL_BITS-1:0] residual_q;

   logic [NUM_COINS-1:0]  sel_d;
   logic [TOTAL_BITS-1:0] sel_value_d;
   logic                  found_d;

   greedy_coin_select #(
      .NUM_COINS  (NUM_COINS),
      .VALUE_BITS (VALUE_BITS),
      .TOTAL_BITS (TOTAL_BITS)
   ) u_select (
      .remaining_i  (remaining_q),
      .coin_value_i (bus.i_coin_value),
      .sel_o        (sel_d),
      .value_o      (sel_value_d),
      .found_o      (found_d)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         timer_q         <= WAIT_LOAD;
         remaining_q     <= '0;
         return_coin_q   <= '0;
         return_amount_q <= '0;
         reject_q        <= '0;
         busy_q          <= 1'b0;
         residual_q      <= '0;
      end else begin
         reject_q <= '0;
         case (state_q)
            IDLE: begin
               return_coin_q   <= '0;
               return_amount_q <= '0;
               if (bus.i_trigger_return) begin
                  timer_q <= '0;
               end else if ((|bus.i_input_coin) || bus.o_output_item_any) begin
                  timer_q <= WAIT_LOAD;
               end else if (timer_q != '0) begin
                  timer_q <= timer_q - TIMER_BITS'(1);
               end
               // Coins landing on this edge are already in the upstream total, not in remaining.
               if ((timer_q == '0 || bus.i_trigger_return) && bus.i_current_total != '0) begin
                  state_q     <= RETURN;
                  remaining_q <= bus.i_current_total;
                  busy_q      <= 1'b1;
                  residual_q  <= '0;
               end
            end
            RETURN: begin
               reject_q <= bus.i_input_coin;
               if (found_d) begin
                  return_coin_q   <= sel_d;
                  return_amount_q <= sel_value_d;
                  remaining_q     <= remaining_q - sel_value_d;
               end else begin
                  // Also the exit once remaining has been driven to zero.
                  return_coin_q   <= '0;
                  return_amount_q <= '0;
                  residual_q      <= remaining_q;
                  state_q         <= DONE;
               end
            end
            DONE: begin
               reject_q        <= bus.i_input_coin;
               return_coin_q   <= '0;
               return_amount_q <= '0;
               residual_q      <= '0;
               remaining_q     <= '0;
               busy_q          <= 1'b0;
               timer_q         <= WAIT_LOAD;
               state_q         <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.o_return_coin   = return_coin_q;
   assign bus.o_return_amount = return_amount_q;
   assign bus.o_reject_coin   = reject_q;
   assign bus.o_busy          = busy_q;
   assign bus.o_residual      = residual_q;
   assign bus.o_wait_time     = timer_q;

endmodule

// File: tb/tb_coin_return_ctrl.sv
// Bench for coin_return_ctrl: directed scenarios plus a random phase, checked
// against a timer-rule model and a greedy change list computed from the start total.
module tb_coin_return_ctrl;
   import coin_return_ctrl_pkg::*;

   localparam int NC  = 3;
   localparam int VB  = 32;
   localparam int TB  = 31;
   localparam int WC  = 10;
   localparam int TMB = 32;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   coin_return_ctrl_if #(.NUM_COINS(NC), .VALUE_BITS(VB), .TOTAL_BITS(TB), .TIMER_BITS(TMB)) bus ();

   coin_return_ctrl #(
      .NUM_COINS(NC), .VALUE_BITS(VB), .TOTAL_BITS(TB), .WAIT_CYCLES(WC), .TIMER_BITS(TMB)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int          checks = 0;
   int          errors = 0;
   int unsigned total;
   int unsigned vals [NC];
   int unsigned exp_timer;

   task automatic chk(input string tag, input longint obs, input longint req);
      checks++;
      if (obs !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, req);
      end
   endtask

   task automatic set_vals(input int unsigned v0, input int unsigned v1, input int unsigned v2);
      vals[0] = v0;
      vals[1] = v1;
      vals[2] = v2;
      for (int k = 0; k < NC; k++) bus.i_coin_value[k*VB +: VB] = vals[k];
   endtask

   task automatic set_total(input int unsigned t);
      total = t;
      bus.i_current_total = TB'(total);
   endtask

   function automatic logic [NC-1:0] rand_coin();
      int r;
      r = int'($urandom_range(0, NC));
      rand_coin = '0;
      if (r != 0) rand_coin[r-1] = 1'b1;
   endfunction

   task automatic clear_inputs();
      bus.i_input_coin      = '0;
      bus.o_output_item_any = 1'b0;
      bus.i_trigger_return  = 1'b0;
   endtask

   // Called at the first negedge after the return has started.
   task automatic do_return(input int unsigned start_total, input bit noise, input bit abort);
      int unsigned   rem;
      int unsigned   frozen;
      int            q[$];
      int            n;
      logic [NC-1:0] nz;
      rem    = start_total;
      frozen = exp_timer;
      for (int k = NC - 1; k >= 0; k--)
         while (vals[k] != 0 && rem >= vals[k]) begin
            q.push_back(k);
            rem -= vals[k];
         end
      n = q.size();
      for (int i = 0; i <= n + 1; i++) begin
         nz = noise ? rand_coin() : '0;
         bus.i_input_coin      = nz;
         bus.i_trigger_return  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.o_output_item_any = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         chk("reject_echo", bus.o_reject_coin, nz);
         if (i < n) begin
            chk("ret_coin", bus.o_return_coin, 1 << q[i]);
            chk("ret_amount", bus.o_return_amount, vals[q[i]]);
            chk("ret_busy", bus.o_busy, 1);
            chk("ret_timer_frozen", bus.o_wait_time, frozen);
            if (abort) begin
               clear_inputs();
               #2 reset_n = 1'b0;
               #1;
               chk("abort_coin", bus.o_return_coin, 0);
               chk("abort_amount", bus.o_return_amount, 0);
               chk("abort_busy", bus.o_busy, 0);
               chk("abort_reject", bus.o_reject_coin, 0);
               chk("abort_residual", bus.o_residual, 0);
               chk("abort_timer", bus.o_wait_time, WC);
               @(negedge clk);
               chk("abort_hold_coin", bus.o_return_coin, 0);
               reset_n = 1'b1;
               exp_timer = WC;
               set_total(total - vals[q[0]]);
               return;
            end
         end else if (i == n) begin
            chk("done_coin", bus.o_return_coin, 0);
            chk("done_busy", bus.o_busy, 1);
            chk("done_residual", bus.o_residual, rem);
            chk("done_timer_frozen", bus.o_wait_time, frozen);
         end else begin
            chk("post_busy", bus.o_busy, 0);
            chk("post_coin", bus.o_return_coin, 0);
            chk("post_timer", bus.o_wait_time, WC);
         end
      end
      clear_inputs();
      exp_timer = WC;
      set_total(total - (start_total - rem));
   endtask

   // One IDLE clock: inputs applied before the edge, model updated, outputs checked after.
   task automatic cycle(input logic [NC-1:0] coin, input logic item, input logic trig,
                        input bit noise, input bit abort);
      bit          start;
      int unsigned start_total;
      start_total = total;
      start = (exp_timer == 0 || trig) && total != 0;
      if (trig) exp_timer = 0;
      else if (coin != '0 || item) exp_timer = WC;
      else if (exp_timer > 0) exp_timer--;
      bus.i_input_coin      = coin;
      bus.o_output_item_any = item;
      bus.i_trigger_return  = trig;
      @(negedge clk);
      clear_inputs();
      for (int k = 0; k < NC; k++) if (coin[k]) total += vals[k];
      bus.i_current_total = TB'(total);
      chk("wait_time", bus.o_wait_time, exp_timer);
      chk("busy", bus.o_busy, start);
      chk("idle_coin", bus.o_return_coin, 0);
      chk("idle_reject", bus.o_reject_coin, 0);
      if (start) do_return(start_total, noise, abort);
   endtask

   task automatic idle_to_return(input int max_cycles, input bit noise);
      bit s;
      s = 1'b0;
      for (int i = 0; i < max_cycles && !s; i++) begin
         s = (exp_timer == 0) && (total != 0);
         cycle('0, 1'b0, 1'b0, noise, 1'b0);
      end
      if (!s) begin
         checks++;
         errors++;
         $display("FAIL return_start_bound: no return within %0d cycles", max_cycles);
      end
   endtask

   initial begin
      int r;
      clear_inputs();
      set_vals(100, 500, 1000);
      set_total(0);
      exp_timer = WC;
      repeat (3) @(negedge clk);
      chk("rst_coin", bus.o_return_coin, 0);
      chk("rst_amount", bus.o_return_amount, 0);
      chk("rst_reject", bus.o_reject_coin, 0);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_residual", bus.o_residual, 0);
      chk("rst_timer", bus.o_wait_time, WC);
      reset_n = 1'b1;

      // Timeout return of 1600 with reject noise during the sequence.
      cycle(3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_to_return(20, 1'b1);

      // Triggered return of 2700 with repeated denominations.
      cycle(3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle('0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Residual 50, then a coinless return of that residual at the next timeout.
      set_total(650);
      cycle('0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle_to_return(20, 1'b0);

      // Zero-valued smallest coin is never selected.
      set_vals(0, 500, 1000);
      set_total(650);
      cycle('0, 1'b0, 1'b1, 1'b1, 1'b0);
      set_vals(100, 500, 1000);

      // Timeout with zero total holds, then timer reloads on coin and item.
      set_total(0);
      for (int i = 0; i < 15; i++) cycle('0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20 && exp_timer != 3; i++) cycle('0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20 && exp_timer != 1; i++) cycle('0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle('0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_to_return(20, 1'b0);

      // Reset asserted right after the first coin of a return.
      set_total(0);
      cycle(3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle('0, 1'b0, 1'b1, 1'b0, 1'b1);
      idle_to_return(20, 1'b0);

      // Random phase with random ascending denominations.
      r = int'($urandom_range(1, 60));
      set_vals(r, r + $urandom_range(1, 200), r + 200 + $urandom_range(1, 800));
      set_total(0);
      for (int i = 0; i < 120; i++) begin
         r = int'($urandom_range(0, 9));
         case (r)
            0, 1, 2: cycle(NC'(1) << $urandom_range(0, NC - 1), 1'b0, 1'b0, 1'b1, 1'b0);
            3:       cycle('0, 1'b1, 1'b0, 1'b1, 1'b0);
            4:       cycle('0, 1'b0, 1'b1, 1'b1, 1'b0);
            default: cycle('0, 1'b0, 1'b0, 1'b1, 1'b0);
         endcase
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
